// File: rtl/pwm_speed_decoder.sv
// Recovers the 8-bit speed code from an incoming PWM stream by measuring the
// high time over each period, and flags periods of the wrong length.
module pwm_speed_decoder #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwd_data,
    output logic [WIDTH-1:0] speed,
    output logic             speed_valid,
    output logic             locked,
    output logic             period_err
);
    localparam logic [WIDTH:0]   C_ONE    = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   C_PERIOD = (WIDTH+1)'(PERIOD);
    localparam logic [WIDTH:0]   C_SAT    = (WIDTH+1)'(PERIOD + 1);
    localparam logic [WIDTH-1:0] C_FULL   = {WIDTH{1'b1}};

    typedef enum logic {S_IDLE, S_MEASURE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic             w_rise;
    logic [WIDTH:0]   r_period_cnt;
    logic [WIDTH:0]   r_high_cnt;
    logic [WIDTH:0]   w_period_inc;
    logic [WIDTH:0]   w_high_inc;
    logic             w_clear;
    logic             w_good;
    logic             w_bad;
    logic             w_timeout;
    logic [WIDTH-1:0] r_speed;
    logic             r_speed_valid;
    logic             r_locked;
    logic             r_period_err;

    assign w_rise = r_s2 & ~r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= pwd_data;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timeout fires on the edge that would take the count past PERIOD, so a
    // constant level restarts the count and reports exactly once per PERIOD.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_next = S_MEASURE;
                end else begin
                    w_clear = 1'b1;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    if (r_period_cnt == C_PERIOD) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else if (r_period_cnt == C_PERIOD) begin
                    w_timeout = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_period_inc = (r_period_cnt == C_SAT) ? C_SAT : r_period_cnt + C_ONE;
    assign w_high_inc   = (r_high_cnt == C_SAT) ? C_SAT
                        : r_high_cnt + {{WIDTH{1'b0}}, r_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (w_clear) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (w_rise) begin
            r_period_cnt <= C_ONE;
            r_high_cnt   <= C_ONE;
        end else if (w_timeout) begin
            r_period_cnt <= C_ONE;
            r_high_cnt   <= {{WIDTH{1'b0}}, r_s2};
        end else begin
            r_period_cnt <= w_period_inc;
            r_high_cnt   <= w_high_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_period_err  <= 1'b0;
        end else begin
            r_speed_valid <= w_good | w_timeout;
            r_period_err  <= w_bad;
            if (w_good) begin
                // A full-period high count cannot fit in WIDTH bits.
                r_speed  <= (r_high_cnt == C_PERIOD) ? C_FULL : r_high_cnt[WIDTH-1:0];
                r_locked <= 1'b1;
            end else if (w_timeout) begin
                r_speed  <= r_s2 ? C_FULL : '0;
                r_locked <= 1'b1;
            end else if (w_bad) begin
                r_locked <= 1'b0;
            end
        end
    end

    assign speed       = r_speed;
    assign speed_valid = r_speed_valid;
    assign locked      = r_locked;
    assign period_err  = r_period_err;

endmodule

// File: tb/tb_pwm_speed_decoder.sv
// Directed bench for pwm_speed_decoder: table of PWM segments with expected
// report counts, plus hand sequences for reset and a mid-period duty step.
module tb_pwm_speed_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwd_data = 1'b0;
    logic [7:0] speed;
    logic       speed_valid;
    logic       locked;
    logic       period_err;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;

    typedef struct {
        int period;
        int high;
        int nper;
        int exp_valid;
        int exp_err;
        int exp_speed;
        int exp_locked;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    pwm_speed_decoder #(.WIDTH(8), .PERIOD(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwd_data    (pwd_data),
        .speed       (speed),
        .speed_valid (speed_valid),
        .locked      (locked),
        .period_err  (period_err)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (speed_valid) n_valid++;
            if (period_err) n_err++;
            if (speed_valid && period_err) n_both++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Holds pwd_data at v for n cycles; entered and left at posedge+2.
    task automatic run_cycles(input int n, input logic v);
        pwd_data = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic gen_period(input int p, input int h);
        if (h > 0) run_cycles(h, 1'b1);
        if (p - h > 0) run_cycles(p - h, 1'b0);
    endtask

    initial begin
        int v0;
        int e0;
        vecs[0] = '{256,  64, 4, 3, 0, 8'h40, 1};
        vecs[1] = '{256,  16, 3, 3, 0, 8'h10, 1};
        vecs[2] = '{200, 100, 3, 1, 2, 8'h10, 0};
        vecs[3] = '{256, 192, 3, 2, 1, 8'hC0, 1};
        vecs[4] = '{256, 255, 3, 3, 0, 8'hFF, 1};
        vecs[5] = '{512,   0, 1, 2, 0, 8'h00, 1};
        vecs[6] = '{600, 600, 1, 3, 0, 8'hFF, 1};

        repeat (3) @(posedge clk);
        #2;
        check("reset_speed", int'(speed), 0);
        check("reset_valid", int'(speed_valid), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_err", int'(period_err), 0);
        rst_n = 1'b1;
        run_cycles(10, 1'b0);

        for (int i = 0; i < 7; i++) begin
            v0 = n_valid;
            e0 = n_err;
            for (int k = 0; k < vecs[i].nper; k++) gen_period(vecs[i].period, vecs[i].high);
            check($sformatf("vec%0d_valid_cnt", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_err_cnt", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_speed", i), int'(speed), vecs[i].exp_speed);
            check($sformatf("vec%0d_locked", i), int'(locked), vecs[i].exp_locked);
        end

        // Reset in the middle of a period, asynchronous to the clock edge.
        run_cycles(50, 1'b0);
        gen_period(256, 64);
        gen_period(256, 64);
        run_cycles(64, 1'b1);
        run_cycles(36, 1'b0);
        check("prerst_locked", int'(locked), 1);
        check("prerst_speed", int'(speed), 8'h40);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_speed", int'(speed), 0);
        check("rst_async_locked", int'(locked), 0);
        check("rst_async_valid", int'(speed_valid), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        run_cycles(150, 1'b0);
        v0 = n_valid;
        e0 = n_err;
        gen_period(256, 64);
        check("rearm_no_valid", n_valid - v0, 0);
        gen_period(256, 64);
        check("rearm_first_report", n_valid - v0, 1);
        check("rearm_speed", int'(speed), 8'h40);
        check("rearm_err_cnt", n_err - e0, 0);

        // Duty step 0x10 -> 0xC0 part-way through a period.
        v0 = n_valid;
        e0 = n_err;
        gen_period(256, 16);
        for (int c = 0; c < 256; c++) begin
            pwd_data = (c < ((c < 8) ? 16 : 192));
            @(posedge clk);
            #2;
        end
        check("step_transitional", int'(speed), 8'h10);
        for (int k = 0; k < 3; k++) begin
            gen_period(256, 192);
            check($sformatf("step_speed%0d", k), int'(speed), 8'hC0);
        end
        check("step_valid_cnt", n_valid - v0, 5);
        check("step_err_cnt", n_err - e0, 0);
        check("valid_err_exclusive", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
